// File: rtl/serial_word_tx.sv
// Parallel-to-serial front end for the 10010 sequence detector: accepts WIDTH-bit
// words over valid/ready and shifts them out MSB-first on j, with a one-word holding buffer.
module serial_word_tx #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             j,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             j_nxt, bit_valid_nxt, word_done_nxt;
    logic             accept, last;

    assign din_ready = !hold_full && !rst;
    assign busy      = (state == SHIFT) || hold_full;
    assign accept    = din_valid && din_ready;
    assign last      = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            cnt       <= '0;
            j         <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
            cnt       <= cnt_nxt;
            j         <= j_nxt;
            bit_valid <= bit_valid_nxt;
            word_done <= word_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last && !hold_full && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        j_nxt         = IDLE_BIT;
        bit_valid_nxt = 1'b0;
        word_done_nxt = 1'b0;
        sr_nxt        = sr;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        case (state)
            IDLE: begin
                if (accept) begin
                    j_nxt         = din[WIDTH-1];
                    bit_valid_nxt = 1'b1;
                    sr_nxt        = din << 1;
                    cnt_nxt       = CW'(1);
                end
            end
            SHIFT: begin
                j_nxt         = sr[WIDTH-1];
                bit_valid_nxt = 1'b1;
                if (!last) begin
                    sr_nxt  = sr << 1;
                    cnt_nxt = cnt + CW'(1);
                    if (accept) begin
                        hold_nxt      = din;
                        hold_full_nxt = 1'b1;
                    end
                end else begin
                    // The LSB occupies j this edge, so the next word loads unshifted
                    // with cnt at 0 and its MSB follows on the next edge.
                    word_done_nxt = 1'b1;
                    cnt_nxt       = '0;
                    if (hold_full) begin
                        sr_nxt        = hold;
                        hold_full_nxt = 1'b0;
                    end else if (accept) begin
                        sr_nxt = din;
                    end else begin
                        sr_nxt = '0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: a directed vector table, hand-written
// multi-cycle sequences and random traffic, all checked against a bit-queue model.
module tb_serial_word_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, din_valid, din_ready, j, bit_valid, word_done, busy;
    logic [W-1:0] din;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .j(j), .bit_valid(bit_valid), .word_done(word_done), .busy(busy)
    );

    int   compared = 0, mismatched = 0;
    bit   mq[$];
    bit   mlast[$];
    logic ej, ebv, ewd;
    int   cyc = 0;
    bit   started = 0;
    bit   lastAccepted;
    logic preReady;
    int   lowCnt;
    bit   obs[$];
    int   wdq[$];
    int   detq[$];
    int   firstBit, lastBit;
    logic [4:0] hist = 5'b0;
    logic det;

    typedef struct {
        logic         r;
        logic         dv;
        logic [W-1:0] d;
        logic         rdy;
        logic         ej;
        logic         ebv;
        logic         ewd;
        logic         ebusy;
        logic         ew;
    } vec_t;

    vec_t tbl[16];

    task automatic cmpBit(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic cmpInt(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmpVec(input string name, input logic [23:0] act, input logic [23:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: pending bits in a queue; at most one held word means <= W queued bits allow accept.
    task automatic modelEdge(input logic r, input logic dv, input logic [W-1:0] d);
        if (r) begin
            mq.delete();
            mlast.delete();
            ej = 1'b0; ebv = 1'b0; ewd = 1'b0;
        end else begin
            if (dv && mq.size() <= W)
                for (int i = W - 1; i >= 0; i--) begin
                    mq.push_back(d[i]);
                    mlast.push_back(i == 0);
                end
            if (mq.size() > 0) begin
                ej = mq.pop_front(); ebv = 1'b1; ewd = mlast.pop_front();
            end else begin
                ej = 1'b0; ebv = 1'b0; ewd = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        cmpBit("j", j, ej);
        cmpBit("bit_valid", bit_valid, ebv);
        cmpBit("word_done", word_done, ewd);
        cmpBit("busy", busy, mq.size() > 0);
        det  = ({hist[3:0], j} == 5'b10010);
        hist = {hist[3:0], j};
        if (bit_valid) begin
            if (obs.size() == 0) firstBit = cyc;
            obs.push_back(j);
            lastBit = cyc;
        end
        if (word_done) wdq.push_back(cyc);
        if (det) detq.push_back(cyc);
    endtask

    task automatic applyStimulus(input logic r, input logic dv, input logic [W-1:0] d);
        rst = r; din_valid = dv; din = d;
        #1;
        preReady = din_ready;
        cmpBit("din_ready", din_ready, !r && mq.size() <= W);
        if (started) cmpBit("busy_pre", busy, mq.size() > 0);
        lastAccepted = dv && !r && mq.size() <= W;
        modelEdge(r, dv, d);
        @(posedge clk);
        #1;
        cyc++;
        started = 1;
        checkOutput();
    endtask

    task automatic sendWords(input int n, input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input logic [W-1:0] w2, output int acc0, output int acc1, output int acc2);
        logic [W-1:0] w[3];
        int           a[3];
        int           idx  = 0;
        bit           done = 0;
        logic [23:0]  got  = '0;
        logic [23:0]  want;
        w = '{w0, w1, w2};
        a = '{-1, -1, -1};
        obs.delete(); wdq.delete(); detq.delete();
        lowCnt = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            if (idx < n) begin
                if (!din_ready) lowCnt++;
                applyStimulus(1'b0, 1'b1, w[idx]);
                if (lastAccepted) begin
                    a[idx] = cyc;
                    idx++;
                end
            end else begin
                applyStimulus(1'b0, 1'b0, W'($urandom));
                if (!busy && !bit_valid) done = 1;
            end
        end
        if (!done) cmpInt("send_timeout", 0, 1);
        want = {w0, w1, w2} >> (8 * (3 - n));
        for (int k = 0; k < obs.size() && k < 24; k++) got = {got[22:0], obs[k]};
        cmpInt("stream_len", obs.size(), W * n);
        cmpVec("stream_bits", got, want);
        acc0 = a[0]; acc1 = a[1]; acc2 = a[2];
    endtask

    initial begin
        int a0, a1, a2;
        rst = 1'b1; din_valid = 1'b0; din = '0;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 2; i < 7; i++)
            tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h90, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].r, tbl[i].dv, tbl[i].d);
            cmpBit($sformatf("tbl%0d_ready", i), preReady, tbl[i].rdy);
            cmpBit($sformatf("tbl%0d_j", i), j, tbl[i].ej);
            cmpBit($sformatf("tbl%0d_bit_valid", i), bit_valid, tbl[i].ebv);
            cmpBit($sformatf("tbl%0d_word_done", i), word_done, tbl[i].ewd);
            cmpBit($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
            cmpBit($sformatf("tbl%0d_detect", i), det, tbl[i].ew);
        end

        $display("[TB] back-to-back A5 3C");
        sendWords(2, 8'hA5, 8'h3C, 8'h00, a0, a1, a2);
        cmpInt("b2b_second_accept", a1, a0 + 1);
        cmpInt("b2b_wd_count", wdq.size(), 2);
        if (wdq.size() >= 2) begin
            cmpInt("b2b_wd_first", wdq[0], a0 + 7);
            cmpInt("b2b_wd_second", wdq[1], a0 + 15);
        end
        cmpInt("b2b_contiguous", lastBit - firstBit + 1, 16);

        $display("[TB] backpressure C3 5A E7");
        sendWords(3, 8'hC3, 8'h5A, 8'hE7, a0, a1, a2);
        cmpInt("bp_second_accept", a1, a0 + 1);
        cmpInt("bp_third_accept", a2, a0 + 8);
        cmpInt("bp_ready_low_cycles", lowCnt, 6);
        cmpInt("bp_contiguous", lastBit - firstBit + 1, 24);

        $display("[TB] reset mid-word");
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'h55);
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        cmpBit("rst_mid_j", j, 1'b0);
        cmpBit("rst_mid_bit_valid", bit_valid, 1'b0);
        cmpBit("rst_mid_busy", busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        sendWords(1, 8'h81, 8'h00, 8'h00, a0, a1, a2);

        $display("[TB] cross-boundary detection");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        sendWords(2, 8'h04, 8'hB3, 8'h00, a0, a1, a2);
        cmpInt("cross_det_count", detq.size(), 1);
        if (detq.size() >= 1) cmpInt("cross_det_cycle", detq[0], a0 + 9);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++)
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, W'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
